// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream in / register-write out bundle for uart_cmd_decoder.
//   rx_data, rx_valid        : received byte and its one-cycle valid pulse
//   wr_en, wr_addr, wr_data  : register-write strobe plus last good address/data
//   err_chksum, err_timeout  : one-cycle error pulses
//   busy                     : a frame is in progress
// master = byte source / register-file side, slave = decoder.
interface uart_cmd_decoder_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        err_chksum;
   logic        err_timeout;
   logic        busy;

   modport master (
      output rx_data, rx_valid,
      input  wr_en, wr_addr, wr_data, err_chksum, err_timeout, busy
   );

   modport slave (
      input  rx_data, rx_valid,
      output wr_en, wr_addr, wr_data, err_chksum, err_timeout, busy
   );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes 5-byte register-write frames (SYNC, ADDR, DATA_HI, DATA_LO, CHK)
// from a UART receiver byte stream. A good frame yields a one-cycle wr_en with
// wr_addr/wr_data; a bad checksum yields err_chksum; a stalled frame is
// aborted by an inter-byte timeout with err_timeout.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_cmd_decoder_if.slave (rx byte in, write/error/busy out)
module uart_cmd_decoder #(
   parameter int unsigned CLK_FREQ     = 50000000,
   parameter int unsigned BAUD         = 500000,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_cmd_decoder_if.slave  bus
);

   localparam int unsigned BIT_CLKS     = (CLK_FREQ + BAUD) / BAUD;
   localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * BIT_CLKS;
   localparam int unsigned CTR_W        = $clog2(TIMEOUT_CLKS);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DHI,
      S_DLO,
      S_CHK
   } state_t;

   state_t           state_q, state_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic [7:0]       acc_q, acc_d;
   logic [7:0]       addr_sh_q, addr_sh_d;
   logic [7:0]       dhi_sh_q, dhi_sh_d;
   logic [7:0]       dlo_sh_q, dlo_sh_d;
   logic             wr_en_q, wr_en_d;
   logic [7:0]       wr_addr_q, wr_addr_d;
   logic [15:0]      wr_data_q, wr_data_d;
   logic             err_chk_q, err_chk_d;
   logic             err_to_q, err_to_d;

   logic [7:0]       chk_sum;
   logic             timeout_hit;

   // Running sum including the incoming byte; a good frame totals zero mod 256.
   assign chk_sum     = acc_q + bus.rx_data;
   // Terminal count with no byte this cycle; a byte on the same cycle wins.
   assign timeout_hit = (state_q != S_IDLE) && !bus.rx_valid && (ctr_q == CTR_LAST);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ctr_q     <= '0;
         acc_q     <= '0;
         addr_sh_q <= '0;
         dhi_sh_q  <= '0;
         dlo_sh_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_chk_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctr_q     <= ctr_d;
         acc_q     <= acc_d;
         addr_sh_q <= addr_sh_d;
         dhi_sh_q  <= dhi_sh_d;
         dlo_sh_q  <= dlo_sh_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_chk_q <= err_chk_d;
         err_to_q  <= err_to_d;
      end
   end

   // Next-state, datapath and pulse generation.
   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      acc_d     = acc_q;
      addr_sh_d = addr_sh_q;
      dhi_sh_d  = dhi_sh_q;
      dlo_sh_d  = dlo_sh_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_chk_d = 1'b0;
      err_to_d  = 1'b0;

      // Inter-byte counter: runs while a frame is open, restarts on each byte.
      if (state_q != S_IDLE) begin
         if (bus.rx_valid) begin
            ctr_d = '0;
         end else begin
            ctr_d = ctr_q + CTR_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            ctr_d = '0;
            if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
               state_d = S_ADDR;
               acc_d   = '0;
            end
         end
         S_ADDR: begin
            if (bus.rx_valid) begin
               addr_sh_d = bus.rx_data;
               acc_d     = chk_sum;
               state_d   = S_DHI;
            end
         end
         S_DHI: begin
            if (bus.rx_valid) begin
               dhi_sh_d = bus.rx_data;
               acc_d    = chk_sum;
               state_d  = S_DLO;
            end
         end
         S_DLO: begin
            if (bus.rx_valid) begin
               dlo_sh_d = bus.rx_data;
               acc_d    = chk_sum;
               state_d  = S_CHK;
            end
         end
         S_CHK: begin
            if (bus.rx_valid) begin
               state_d = S_IDLE;
               if (chk_sum == 8'd0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_sh_q;
                  wr_data_d = {dhi_sh_q, dlo_sh_q};
               end else begin
                  err_chk_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort a stalled frame.
      if (timeout_hit) begin
         state_d  = S_IDLE;
         ctr_d    = '0;
         err_to_d = 1'b1;
      end
   end

   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.err_chksum  = err_chk_q;
   assign bus.err_timeout = err_to_q;
   // busy follows the state directly.
   assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames plus randomized
// byte streams, checked against a frame-level reference model that predicts
// every output pulse and the cycle it appears in.
module tb_uart_cmd_decoder;

   localparam int          TC   = 20 * ((50000000 + 500000) / 500000);
   localparam logic [7:0]  SYNC = 8'hA5;
   localparam logic [1:0]  K_WR = 2'd1, K_CHK = 2'd2, K_TO = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] cyc;
      logic [7:0]  addr;
      logic [15:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_cmd_decoder_if bus();

   uart_cmd_decoder #(
      .CLK_FREQ(50000000), .BAUD(500000), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   ev_t exp_q[$];
   ev_t obs_q[$];

   // Reference model state: bytes of the open frame, edge of last accepted byte.
   logic [7:0]  m_frame[$];
   int          m_last;
   logic [7:0]  exp_addr;
   logic [15:0] exp_data;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pulse with the edge count it follows.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.wr_en === 1'b1)       obs_q.push_back({K_WR, 32'(cyc), bus.wr_addr, bus.wr_data});
         if (bus.err_chksum === 1'b1)  obs_q.push_back({K_CHK, 32'(cyc), 8'h00, 16'h0000});
         if (bus.err_timeout === 1'b1) obs_q.push_back({K_TO, 32'(cyc), 8'h00, 16'h0000});
      end
   end

   function automatic ev_t mk(input logic [1:0] k, input int c, input logic [7:0] a, input logic [15:0] d);
      mk = {k, 32'(c), a, d};
   endfunction

   // A frame is abandoned when no byte arrives within TC edges of the last one.
   task automatic model_idle(input int now);
      if (m_frame.size() > 0 && now >= m_last + TC) begin
         exp_q.push_back(mk(K_TO, m_last + TC, 8'h00, 16'h0000));
         m_frame.delete();
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input int a);
      int s;
      model_idle(a - 1);
      if (m_frame.size() == 0) begin
         if (b == SYNC) begin
            m_frame.push_back(b);
            m_last = a;
         end
      end else begin
         m_frame.push_back(b);
         m_last = a;
         if (m_frame.size() == 5) begin
            s = 0;
            for (int i = 1; i < 5; i++) s += int'(m_frame[i]);
            if (s % 256 == 0) begin
               exp_addr = m_frame[1];
               exp_data = {m_frame[2], m_frame[3]};
               exp_q.push_back(mk(K_WR, a, exp_addr, exp_data));
            end else begin
               exp_q.push_back(mk(K_CHK, a, 8'h00, 16'h0000));
            end
            m_frame.delete();
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Entry/exit invariant: 1 time unit after a rising edge, rx_valid low.
   task automatic send_byte(input logic [7:0] b, input int gap);
      idle(gap);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      model_byte(b, cyc + 1);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] b[], input int gap);
      foreach (b[i]) send_byte(b[i], gap);
   endtask

   task automatic start_test();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic do_reset_release();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rst_n        = 1'b0;
      m_frame.delete();
      exp_addr = 8'h00;
      exp_data = 16'h0000;
      #12;
      checks++;
      if ({bus.wr_en, bus.err_chksum, bus.err_timeout, bus.busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b want 0000", {bus.wr_en, bus.err_chksum, bus.err_timeout, bus.busy});
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== 24'h0) begin
         failures++;
         $display("FAIL reset_regs: got addr=%h data=%h want 00/0000", bus.wr_addr, bus.wr_data);
      end
      do_reset_release();
   endtask

   task automatic test_good_frame();
      logic [7:0] f[] = '{8'hA5, 8'h10, 8'h12, 8'h34, 8'hAA};
      start_test();
      send_seq(f, 0);
      idle(4);
      model_idle(cyc);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL good_count: got %0d events want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL good_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== {8'h10, 16'h1234}) begin
         failures++;
         $display("FAIL good_regs: got %h/%h want 10/1234", bus.wr_addr, bus.wr_data);
      end
   endtask

   task automatic test_bad_chksum();
      logic [7:0] f[] = '{8'hA5, 8'h10, 8'h12, 8'h34, 8'hAB};
      start_test();
      send_seq(f, 0);
      idle(4);
      model_idle(cyc);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL bad_count: got %0d events want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL bad_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== {8'h10, 16'h1234}) begin
         failures++;
         $display("FAIL bad_regs_held: got %h/%h want 10/1234", bus.wr_addr, bus.wr_data);
      end
   endtask

   task automatic test_garbage();
      logic [7:0] f[] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h02, 8'hFD};
      start_test();
      send_seq(f, 1);
      idle(4);
      model_idle(cyc);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL garbage_count: got %0d events want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL garbage_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== {8'h01, 16'h0002}) begin
         failures++;
         $display("FAIL garbage_regs: got %h/%h want 01/0002", bus.wr_addr, bus.wr_data);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] f[] = '{8'hA5, 8'h20, 8'hAB, 8'hCD, 8'h68};
      start_test();
      send_byte(8'hA5, 0);
      send_byte(8'h01, 0);
      idle(TC);
      checks++;
      if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse: got err_timeout=%b busy=%b want 1/0", bus.err_timeout, bus.busy);
      end
      // A byte landing on the terminal-count cycle keeps the frame alive.
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, TC - 1);
      send_byte(8'h05, TC - 1);
      send_byte(8'hF4, 0);
      send_seq(f, 0);
      idle(4);
      model_idle(cyc);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL timeout_count: got %0d events want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL timeout_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== {8'h20, 16'hABCD}) begin
         failures++;
         $display("FAIL timeout_regs: got %h/%h want 20/abcd", bus.wr_addr, bus.wr_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] f[] = '{8'hA5, 8'h20, 8'hAB, 8'hCD, 8'h68,
                          8'hA5, 8'hA5, 8'hA5, 8'h01, 8'hB5};
      start_test();
      send_seq(f, 0);
      idle(4);
      model_idle(cyc);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL b2b_count: got %0d events want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL b2b_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== {8'hA5, 16'hA501}) begin
         failures++;
         $display("FAIL b2b_regs: got %h/%h want a5/a501", bus.wr_addr, bus.wr_data);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] f[] = '{8'h12, 8'h34, 8'hAA};
      start_test();
      send_byte(8'hA5, 0);
      send_byte(8'h10, 0);
      #2;
      rst_n = 1'b0;
      m_frame.delete();
      exp_addr = 8'h00;
      exp_data = 16'h0000;
      #1;
      checks++;
      if ({bus.busy, bus.wr_addr, bus.wr_data} !== 25'h0) begin
         failures++;
         $display("FAIL midreset_async: got busy=%b addr=%h data=%h want 0", bus.busy, bus.wr_addr, bus.wr_data);
      end
      do_reset_release();
      send_seq(f, 0);
      idle(TC + 5);
      model_idle(cyc);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL midreset_count: got %0d events want %0d", obs_q.size(), exp_q.size());
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data} !== {exp_addr, exp_data}) begin
         failures++;
         $display("FAIL midreset_regs: got %h/%h want %h/%h", bus.wr_addr, bus.wr_data, exp_addr, exp_data);
      end
   endtask

   function automatic int pick_gap();
      int r = int'($urandom_range(0, 59));
      if (r == 0) return TC - 1;
      if (r == 1) return TC;
      if (r == 2) return TC + int'($urandom_range(1, 4));
      return int'($urandom_range(0, 2));
   endfunction

   task automatic test_random();
      logic [7:0] fr[5];
      logic [7:0] s;
      start_test();
      for (int f = 0; f < 50; f++) begin
         int ng = int'($urandom_range(0, 2));
         for (int g = 0; g < ng; g++) send_byte(8'($urandom), int'($urandom_range(0, 3)));
         fr[0] = SYNC;
         for (int k = 1; k < 4; k++) fr[k] = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
         s = fr[1] + fr[2] + fr[3];
         fr[4] = 8'(8'd0 - s);
         if ($urandom_range(0, 3) == 0) fr[4] = fr[4] ^ 8'(1 << $urandom_range(0, 7));
         for (int k = 0; k < 5; k++) send_byte(fr[k], pick_gap());
      end
      idle(TC + 5);
      model_idle(cyc);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL random_count: got %0d events want %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if ({bus.wr_addr, bus.wr_data, bus.busy} !== {exp_addr, exp_data, 1'b0}) begin
         failures++;
         $display("FAIL random_regs: got %h/%h busy=%b want %h/%h busy=0",
                  bus.wr_addr, bus.wr_data, bus.busy, exp_addr, exp_data);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_chksum();
      test_garbage();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
